exc_sequencer: RTL and testbench

- Multicycle exception sequencer for the processor control path.
- On an invalid-opcode, overflow or divide-by-zero event, it runs the fixed service sequence:
  - saves EPC;
  - steers the memory-address mux to vector slot 253/254/255;
  - reads the handler byte and loads it into PC.
- Sits beside the main control FSM, which stalls while busy is high and resumes on done.

---
 rtl/exc_sequencer.sv | 111 +++++++++++
 tb/tb_exc_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// Multicycle exception sequencer: saves EPC, fetches the handler byte
// from vector slot 253..255 and loads it into PC while the main FSM stalls.
module exc_sequencer #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       exc_en,
    input  logic       opcode_inv,
    input  logic       overflow,
    input  logic       div_zero,
    output logic       busy,
    output logic       done,
    output logic [1:0] cause,
    output logic [2:0] addr_sel,
    output logic       mem_read,
    output logic       epc_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic       pc_src_exc
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SAVE = 3'd1,
        WAIT = 3'd2,
        LOAD = 3'd3,
        JUMP = 3'd4
    } state_t;

    state_t     state;
    logic [1:0] cause_q;
    logic [3:0] cnt;
    logic [2:0] vec_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cause_q <= 2'b00;
            cnt     <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (exc_en && (opcode_inv || overflow || div_zero)) begin
                        if (opcode_inv)
                            cause_q <= 2'b01;
                        else if (overflow)
                            cause_q <= 2'b10;
                        else
                            cause_q <= 2'b11;
                        state <= SAVE;
                    end
                end
                SAVE: begin
                    cnt   <= 4'(MEM_WAIT);
                    state <= (MEM_WAIT > 0) ? WAIT : LOAD;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= LOAD;
                end
                LOAD: state <= JUMP;
                JUMP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Vector slot: cause 01/10/11 maps to mux codes 010/011/100 (addr 253..255)
    assign vec_sel = {1'b0, cause_q} + 3'd1;
    assign cause   = cause_q;

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        addr_sel   = 3'b000;
        mem_read   = 1'b0;
        epc_write  = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src_exc = 1'b0;
        unique case (state)
            SAVE: begin
                busy      = 1'b1;
                epc_write = 1'b1;
                mem_read  = 1'b1;
                addr_sel  = vec_sel;
            end
            WAIT: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                addr_sel = vec_sel;
            end
            LOAD: begin
                busy      = 1'b1;
                mem_read  = 1'b1;
                mdr_write = 1'b1;
                addr_sel  = vec_sel;
            end
            JUMP: begin
                busy       = 1'b1;
                done       = 1'b1;
                pc_write   = 1'b1;
                pc_src_exc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer; three builds (MEM_WAIT 1, 0, 15)
// share the same stimulus.
module tb_exc_sequencer;

    logic clk = 1'b0;
    logic reset, exc_en, opcode_inv, overflow, div_zero;

    logic       busy_a, done_a, mr_a, ew_a, mw_a, pw_a, ps_a;
    logic [1:0] cause_a;
    logic [2:0] addr_a;
    logic       busy_b, done_b, mr_b, ew_b, mw_b, pw_b, ps_b;
    logic [1:0] cause_b;
    logic [2:0] addr_b;
    logic       busy_c, done_c, mr_c, ew_c, mw_c, pw_c, ps_c;
    logic [1:0] cause_c;
    logic [2:0] addr_c;

    logic [11:0] v_a, v_b;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    exc_sequencer #(.MEM_WAIT(1)) dut_a (
        .clk(clk), .reset(reset), .exc_en(exc_en),
        .opcode_inv(opcode_inv), .overflow(overflow), .div_zero(div_zero),
        .busy(busy_a), .done(done_a), .cause(cause_a), .addr_sel(addr_a),
        .mem_read(mr_a), .epc_write(ew_a), .mdr_write(mw_a),
        .pc_write(pw_a), .pc_src_exc(ps_a)
    );

    exc_sequencer #(.MEM_WAIT(0)) dut_b (
        .clk(clk), .reset(reset), .exc_en(exc_en),
        .opcode_inv(opcode_inv), .overflow(overflow), .div_zero(div_zero),
        .busy(busy_b), .done(done_b), .cause(cause_b), .addr_sel(addr_b),
        .mem_read(mr_b), .epc_write(ew_b), .mdr_write(mw_b),
        .pc_write(pw_b), .pc_src_exc(ps_b)
    );

    exc_sequencer #(.MEM_WAIT(15)) dut_c (
        .clk(clk), .reset(reset), .exc_en(exc_en),
        .opcode_inv(opcode_inv), .overflow(overflow), .div_zero(div_zero),
        .busy(busy_c), .done(done_c), .cause(cause_c), .addr_sel(addr_c),
        .mem_read(mr_c), .epc_write(ew_c), .mdr_write(mw_c),
        .pc_write(pw_c), .pc_src_exc(ps_c)
    );

    assign v_a = {busy_a, done_a, cause_a, addr_a, mr_a, ew_a, mw_a, pw_a, ps_a};
    assign v_b = {busy_b, done_b, cause_b, addr_b, mr_b, ew_b, mw_b, pw_b, ps_b};

    // Order: busy, done, cause, addr_sel, mem_read, epc_write, mdr_write, pc_write, pc_src_exc
    function automatic logic [11:0] ev(input logic b, input logic d,
                                       input logic [1:0] c, input logic [2:0] a,
                                       input logic mr, input logic ew,
                                       input logic mw, input logic pw,
                                       input logic ps);
        return {b, d, c, a, mr, ew, mw, pw, ps};
    endfunction

    function automatic logic [11:0] idle_v(input logic [1:0] c);
        return ev(0, 0, c, 3'b000, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [11:0] save_v(input logic [1:0] c, input logic [2:0] a);
        return ev(1, 0, c, a, 1, 1, 0, 0, 0);
    endfunction
    function automatic logic [11:0] wait_v(input logic [1:0] c, input logic [2:0] a);
        return ev(1, 0, c, a, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [11:0] load_v(input logic [1:0] c, input logic [2:0] a);
        return ev(1, 0, c, a, 1, 0, 1, 0, 0);
    endfunction
    function automatic logic [11:0] jump_v(input logic [1:0] c);
        return ev(1, 1, c, 3'b000, 0, 0, 0, 1, 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input logic en, input logic oi, input logic ov, input logic dz);
        exc_en = en;
        opcode_inv = oi;
        overflow = ov;
        div_zero = dz;
    endtask

    initial begin
        int c_b;
        int c_c;
        int n_c;
        reset = 1'b0;
        flags(1, 1, 0, 0);

        // 1: reset dominates pending flags, then SAVE on first free edge
        step();
        step();
        chk("rst_idle", 32'(v_a), 32'(idle_v(2'b00)));
        reset = 1'b1;
        step();
        chk("rst_save", 32'(v_a), 32'(save_v(2'b01, 3'b010)));
        flags(0, 0, 0, 0);
        step();
        chk("rst_wait", 32'(v_a), 32'(wait_v(2'b01, 3'b010)));
        step();
        chk("rst_load", 32'(v_a), 32'(load_v(2'b01, 3'b010)));
        step();
        chk("rst_jump", 32'(v_a), 32'(jump_v(2'b01)));
        step();
        chk("rst_end", 32'(v_a), 32'(idle_v(2'b01)));

        // 2: overflow, MEM_WAIT=1
        flags(1, 0, 1, 0);
        step();
        flags(0, 0, 0, 0);
        chk("ov_save", 32'(v_a), 32'(save_v(2'b10, 3'b011)));
        step();
        chk("ov_wait", 32'(v_a), 32'(wait_v(2'b10, 3'b011)));
        step();
        chk("ov_load", 32'(v_a), 32'(load_v(2'b10, 3'b011)));
        step();
        chk("ov_jump", 32'(v_a), 32'(jump_v(2'b10)));
        step();
        chk("ov_idle", 32'(v_a), 32'(idle_v(2'b10)));

        // 3: simultaneous opcode + div0, opcode wins
        flags(1, 1, 0, 1);
        step();
        flags(0, 0, 0, 0);
        chk("pri_save", 32'(v_a), 32'(save_v(2'b01, 3'b010)));
        step();
        chk("pri_wait", 32'(v_a), 32'(wait_v(2'b01, 3'b010)));
        step();
        chk("pri_load", 32'(v_a), 32'(load_v(2'b01, 3'b010)));
        step();
        chk("pri_jump", 32'(v_a), 32'(jump_v(2'b01)));
        step();
        chk("pri_idle", 32'(v_a), 32'(idle_v(2'b01)));

        // 4: gated div0, then enabled; held flag retriggers after done
        flags(0, 0, 0, 1);
        step();
        step();
        chk("dz_gated", 32'(v_a), 32'(idle_v(2'b01)));
        exc_en = 1'b1;
        step();
        chk("dz_save", 32'(v_a), 32'(save_v(2'b11, 3'b100)));
        step();
        chk("dz_wait", 32'(v_a), 32'(wait_v(2'b11, 3'b100)));
        step();
        chk("dz_load", 32'(v_a), 32'(load_v(2'b11, 3'b100)));
        step();
        chk("dz_jump", 32'(v_a), 32'(jump_v(2'b11)));
        step();
        chk("dz_gap", 32'(v_a), 32'(idle_v(2'b11)));
        step();
        flags(0, 0, 0, 0);
        chk("dz_retrig", 32'(v_a), 32'(save_v(2'b11, 3'b100)));
        step();
        step();
        step();
        chk("dz_rejump", 32'(v_a), 32'(jump_v(2'b11)));
        step();
        chk("dz_end", 32'(v_a), 32'(idle_v(2'b11)));

        // 5: flags ignored while busy; reset in LOAD aborts without done
        flags(1, 0, 1, 0);
        step();
        chk("ign_save", 32'(v_a), 32'(save_v(2'b10, 3'b011)));
        flags(1, 1, 1, 1);
        step();
        chk("ign_wait", 32'(v_a), 32'(wait_v(2'b10, 3'b011)));
        flags(0, 0, 0, 0);
        step();
        chk("ign_load", 32'(v_a), 32'(load_v(2'b10, 3'b011)));
        #2;
        reset = 1'b0;
        #1;
        chk("abort_async", 32'(v_a), 32'(idle_v(2'b00)));
        step();
        chk("abort_nojump", 32'(v_a), 32'(idle_v(2'b00)));
        chk("abort_pcw", 32'(pw_a | done_a), 32'd0);
        reset = 1'b1;
        step();
        chk("abort_stay", 32'(v_a), 32'(idle_v(2'b00)));

        // 6: latency for MEM_WAIT=0 and MEM_WAIT=15 builds
        flags(1, 0, 1, 0);
        step();
        flags(0, 0, 0, 0);
        chk("mw0_save", 32'(v_b), 32'(save_v(2'b10, 3'b011)));
        c_b = (done_b === 1'b1) ? 1 : 0;
        c_c = (done_c === 1'b1) ? 1 : 0;
        n_c = (done_c === 1'b1) ? 1 : 0;
        step();
        chk("mw0_load", 32'(v_b), 32'(load_v(2'b10, 3'b011)));
        for (int cyc = 2; cyc <= 22; cyc++) begin
            if (done_b === 1'b1 && c_b == 0) c_b = cyc;
            if (done_c === 1'b1) begin
                n_c++;
                if (c_c == 0) c_c = cyc;
            end
            if (cyc == 3) chk("mw0_jump", 32'(v_b), 32'(jump_v(2'b10)));
            step();
        end
        chk("mw0_done_cyc", 32'(c_b), 32'd3);
        chk("mw15_done_cyc", 32'(c_c), 32'd18);
        chk("mw15_done_cnt", 32'(n_c), 32'd1);
        chk("mw15_idle", 32'({busy_c, cause_c}), 32'({1'b0, 2'b10}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
